// File: rtl/aes_pkg.sv
// Shared AES state types used by the dematrixify datapath.
// The state is a 4x4 byte matrix, indexed [row][col].
package aes_pkg;
   typedef logic [7:0]          byte_t;
   typedef byte_t [3:0][3:0]    state_t;

   localparam int STATE_BITS = 128;
   localparam int FIFO_DEPTH = 2;
endpackage : aes_pkg

// File: rtl/state_dematrixify_if.sv
// Producer/consumer bundle for the state dematrixifier.
// The slave side is the dematrixifier; the master side is its environment.
interface state_dematrixify_if;
   import aes_pkg::*;

   state_t                  matrix;
   logic                    in_valid;
   logic                    in_ready;
   logic [STATE_BITS-1:0]   rawstring_comb;
   logic [STATE_BITS-1:0]   rawstring;
   logic                    out_valid;
   logic                    out_ready;

   modport slave (
      input  matrix, in_valid, out_ready,
      output in_ready, rawstring_comb, rawstring, out_valid
   );

   modport master (
      output matrix, in_valid, out_ready,
      input  in_ready, rawstring_comb, rawstring, out_valid
   );
endinterface : state_dematrixify_if

// File: rtl/dematrixify_core.sv
// Pure wiring: flattens a 4x4 state matrix into a column-major 128-bit string,
// one column per 32-bit word with the row-3 byte most significant.
module dematrixify_core
   import aes_pkg::*;
(
   input  state_t                matrix,
   output logic [STATE_BITS-1:0] rawstring
);

   always_comb begin
      rawstring = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            rawstring[8*(4*c+r) +: 8] = matrix[r][c];
         end
      end
   end

endmodule : dematrixify_core

// File: rtl/state_dematrixify.sv
// Matrix-to-string converter with a combinational view and a 2-entry
// ready/valid buffered registered output.
module state_dematrixify
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   state_dematrixify_if.slave bus
);

   logic [STATE_BITS-1:0] flat;
   logic [STATE_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [1:0]            count_q, count_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  push, pop;

   dematrixify_core u_core (
      .matrix    (bus.matrix),
      .rawstring (flat)
   );

   assign bus.rawstring_comb = flat;

   // Ready is a function of occupancy only, so no combinational path from out_ready.
   assign bus.in_ready  = (count_q < 2'(FIFO_DEPTH));
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.rawstring = bus.out_valid ? mem_q[rd_ptr_q] : '0;

   assign push = bus.in_valid  && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; an empty buffer masks its contents on rawstring.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= flat;
   end

endmodule : state_dematrixify

// File: tb/tb_state_dematrixify.sv
// Directed plus randomized bench for state_dematrixify, checked against a
// queue-based reference model of the flattening and the 2-deep buffer.
module tb_state_dematrixify;
   import aes_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [127:0] q[$];

   state_dematrixify_if bus ();

   state_dematrixify dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] ref_flat(input state_t m);
      logic [127:0] s;
      s = '0;
      for (int k = 0; k < 16; k++) s[8*k +: 8] = m[k % 4][k / 4];
      return s;
   endfunction

   function automatic state_t rand_state();
      state_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = 8'($urandom);
      return m;
   endfunction

   function automatic state_t fill_state(input logic [7:0] b);
      state_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = b;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".in_ready"},  128'(bus.in_ready),  128'(q.size() < 2));
      chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(q.size() > 0));
      chk({tag, ".rawstring"}, bus.rawstring, (q.size() > 0) ? q[0] : 128'h0);
      chk({tag, ".comb"},      bus.rawstring_comb, ref_flat(bus.matrix));
   endtask

   // One clock: model acts on the inputs presented before the edge.
   task automatic tick();
      logic         do_push, do_pop;
      logic [127:0] d;
      do_push = bus.in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && bus.out_ready;
      d       = ref_flat(bus.matrix);
      @(posedge clk);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
      @(negedge clk);
   endtask

   initial begin
      state_t       tv;
      logic [127:0] v;
      logic [127:0] golden;

      bus.matrix    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      golden = 128'h121b1904_637a1279_74620d15_77056458;

      @(negedge clk);
      chk("reset.out_valid", 128'(bus.out_valid), 128'h0);
      chk("reset.in_ready",  128'(bus.in_ready),  128'h1);
      chk("reset.rawstring", bus.rawstring,       128'h0);
      reset = 1'b0;

      tv[3] = {8'h12, 8'h63, 8'h74, 8'h77};
      tv[2] = {8'h1b, 8'h7a, 8'h62, 8'h05};
      tv[1] = {8'h19, 8'h12, 8'h0d, 8'h64};
      tv[0] = {8'h04, 8'h79, 8'h15, 8'h58};
      bus.matrix = tv;
      #1;
      v = bus.rawstring_comb;
      chk("comb.vector", v, golden);
      chk("comb.b127", 128'(v[127:120]), 128'h12);
      chk("comb.b111", 128'(v[111:104]), 128'h19);
      chk("comb.b87",  128'(v[87:80]),   128'h7a);
      chk("comb.b47",  128'(v[47:40]),   128'h0d);
      chk("comb.b23",  128'(v[23:16]),   128'h05);
      chk("comb.b7",   128'(v[7:0]),     128'h58);
      chk("comb.model", v, ref_flat(tv));

      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("lat.out_valid", 128'(bus.out_valid), 128'h1);
      chk("lat.rawstring", bus.rawstring, golden);
      chk_model("lat");
      tick();
      chk("lat.drain", 128'(bus.out_valid), 128'h0);
      chk_model("lat.after");

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.matrix    = fill_state(8'h11);
      tick();
      bus.matrix = fill_state(8'hAA);
      tick();
      bus.in_valid = 1'b0;
      chk("bp.in_ready",  128'(bus.in_ready), 128'h0);
      chk("bp.head",      bus.rawstring, {16{8'h11}});
      tick();
      tick();
      chk("bp.stall",     bus.rawstring, {16{8'h11}});
      chk("bp.stall_vld", 128'(bus.out_valid), 128'h1);
      chk_model("bp.stall");
      bus.out_ready = 1'b1;
      tick();
      chk("bp.second", bus.rawstring, {16{8'hAA}});
      chk_model("bp.second");
      tick();
      chk("bp.empty", 128'(bus.out_valid), 128'h0);

      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.matrix = rand_state();
         bus.matrix[0][0] = 8'(i);
         v = ref_flat(bus.matrix);
         tick();
         chk("stream.in_ready", 128'(bus.in_ready), 128'h1);
         chk("stream.data", bus.rawstring, v);
         chk_model("stream");
      end
      bus.in_valid = 1'b0;
      tick();
      chk_model("stream.end");

      for (int i = 0; i < 300; i++) begin
         bus.matrix    = rand_state();
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         tick();
         chk_model("rand");
      end

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.matrix    = rand_state();
      tick();
      bus.matrix = rand_state();
      tick();
      bus.in_valid = 1'b0;
      chk("rst.full", 128'(bus.in_ready), 128'h0);
      #2 reset = 1'b1;
      q.delete();
      #1;
      chk("rst.out_valid", 128'(bus.out_valid), 128'h0);
      chk("rst.rawstring", bus.rawstring,       128'h0);
      chk("rst.in_ready",  128'(bus.in_ready),  128'h1);
      #1 reset = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("rst.no_stale", 128'(bus.out_valid), 128'h0);
      chk_model("rst.after");
      bus.in_valid = 1'b1;
      bus.matrix   = tv;
      tick();
      bus.in_valid = 1'b0;
      chk("rst.repush", bus.rawstring, golden);
      chk_model("rst.repush");
      tick();
      chk_model("rst.final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_state_dematrixify

// File: doc/state_dematrixify.md
# state_dematrixify

Converts a 4×4 AES state matrix of bytes back into a flat 128-bit string in column-major order, the inverse of the matrixify step. It sits at the output of the cipher datapath and turns the final state into the 128-bit ciphertext or plaintext word. It provides a combinational view of the conversion and a registered, ready/valid-handshaked path buffered by a two-entry skid buffer.

## Interface
- No parameters: byte width 8, matrix 4×4 and string width 128 are fixed.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- matrix  input  8 × [3:0][3:0]  state bytes, indexed matrix[row][col].
- in_valid  input  1  matrix holds a valid state.
- in_ready  output  1  the block can accept a state this cycle.
- rawstring_comb  output  128  combinational flattening of the current matrix.
- rawstring  output  128  registered flattened string, head of the buffer.
- out_valid  output  1  rawstring is valid.
- out_ready  input  1  the consumer accepts rawstring this cycle.

## Operation
- Mapping, for r, c in 0..3:
  - rawstring[8*(4c+r)+7 : 8*(4c+r)] = matrix[r][c].
  - Equivalently, rawstring = {m[3][3], m[2][3], m[1][3], m[0][3], m[3][2], …, m[0][0]}.
  - Each 32-bit word is one column. Column 3 occupies bits [127:96] and column 0 occupies bits [31:0].
  - Within a word, the row-3 byte is most significant.
- rawstring_comb applies the mapping to matrix at all times. It ignores in_valid, clk and reset.
- The registered path is a 2-entry FIFO of flattened strings, with occupancy count 0..2.
  - Push: occurs on a clock edge when in_valid && in_ready. The flattened matrix is stored.
  - Pop: occurs on a clock edge when out_valid && out_ready.
  - in_ready = (count < 2). It depends only on state, never combinationally on out_ready.
  - out_valid = (count > 0). rawstring always shows the oldest entry.
  - When count = 0, rawstring = 128'h0.
- Boundary cases:
  - Push and pop in the same cycle with count = 1: count stays 1, and the new string becomes the head on the next cycle.
  - With count = 2: in_ready = 0, so no push occurs. A pop frees one slot.
  - Stall: while out_valid && !out_ready, rawstring and out_valid hold stable.
  - Order is strictly FIFO. No data is lost or duplicated.

## Timing
- Combinational path: zero latency.
- Registered path: latency 1 cycle from push edge to out_valid, when the buffer is empty.
- Full throughput is one string per cycle when out_ready stays high.
- Reset (asynchronous, active-high):
  - Takes effect immediately, including mid-transfer.
  - Sets count = 0, out_valid = 0, rawstring = 0 and in_ready = 1.
  - Contents of both entries are discarded.
- First push is possible on the first rising edge after reset deasserts.

## Structure
- A shared package (aes_pkg) holds:
  - byte_t (8-bit).
  - state_t (byte_t [3:0][3:0]).
  - STATE_BITS = 128.
- One sub-module, dematrixify_core:
  - Purely combinational matrix-to-string mapping.
  - Instantiated once for rawstring_comb, with the same output feeding the FIFO write data.
- The top level holds the two storage registers, read/write pointers or count, and the handshake logic.

## Test plan
- Combinational mapping: drive these rows as {col3, col2, col1, col0}:
  - m[3] = {12, 63, 74, 77}
  - m[2] = {1b, 7a, 62, 05}
  - m[1] = {19, 12, 0d, 64}
  - m[0] = {04, 79, 15, 58}
  - Required: rawstring_comb = 128'h12_1b_19_04_63_7a_12_79_74_62_0d_15_77_05_64_58.
  - Spot checks: [127:120] = 12, [111:104] = 19, [87:80] = 7a, [47:40] = 0d, [23:16] = 05, [7:0] = 58.
- Registered latency: push the matrix above with out_ready = 1.
  - Required: out_valid rises one cycle later with the same 128-bit value.
  - Required: count returns to 0 the following cycle.
- Backpressure: hold out_ready = 0 and push A = all 8'h11, then B = all 8'hAA.
  - Required: in_ready = 0 after the second push.
  - Required: rawstring holds 128'h1111…11.
  - Release out_ready: required output order is A then B.
- Simultaneous push and pop at count = 1: stream 8 distinct matrices with in_valid = out_ready = 1.
  - Required: 8 outputs in order, one per cycle after 1-cycle latency.
  - Required: in_ready never drops.
- Asynchronous reset mid-operation: with count = 2, assert reset between clock edges.
  - Required: out_valid = 0, rawstring = 0 and in_ready = 1 immediately.
  - Required: no stale data appears after reset deasserts.
